booth_seq_ctrl: RTL and testbench
=================================

// Module: booth_seq_ctrl
// PURPOSE
//  Control sequencer for the ALU16 shift/add datapath (17-bit A, 16-bit Q, M, Q[-1]).
//  On start it runs a radix-2 Booth signed multiply, or an optional restoring unsigned divide.
//  It drives the A/Q mode selects, the adder add/sub control and the M load strobe.
//  It reports the busy/done/err handshake to the processor control unit.
// PARAMETERS
//  N      16  operand width = number of iterations
//  CNT_W  5   iteration counter width, must satisfy 2**CNT_W > N
// PORTS
//  clk      in   1      system clock, rising edge
//  rst      in   1      asynchronous, active-high reset
//  start    in   1      operation request, sampled only in IDLE
//  op       in   1      0 = MUL (Booth), 1 = DIV (restoring)
//  q0       in   1      Q[0] from datapath
//  qm1      in   1      Q[-1] from datapath
//  a_sign   in   1      A[16] from datapath
//  m_zero   in   1      M == 0, valid from the cycle after LOAD
//  busy     out  1      high from LOAD through DONE
//  done     out  1      one-cycle pulse in DONE
//  err      out  1      valid with done: divide by zero, or DIV requested while not compiled in
//  a_sel    out  2      A mode: 00 hold, 01 shift right, 10 shift left, 11 load
//  a_src    out  1      A load source: 0 = zero, 1 = adder sum
//  q_sel    out  2      Q mode, same encoding as a_sel (11 = load operand bus)
//  m_ld     out  1      load M from operand bus
//  alu_sub  out  1      adder computes A-M when 1, A+M when 0
//  q0_wr    out  1      force Q[0] <= q0_val (DIV only)
//  q0_val   out  1      value written to Q[0]
//  qm1_clr  out  1      clear Q[-1]
//  cnt      out  CNT_W  completed iteration count
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, every output 0 (selects = hold).
//  Outputs are decoded from state/op (Moore); only the TEST branch reads datapath inputs.
//  IDLE: if start, latch op and go to LOAD; otherwise stay.
//  LOAD (1 cycle): m_ld=1, q_sel=11, a_sel=11 with a_src=0, qm1_clr=1, cnt<=0.
//    MUL -> MTEST.
//    DIV -> DCHK; DCHK goes to DONE with err=1 if m_zero, else DSHL.
//  MUL loop:
//    MTEST: {q0,qm1}=10 -> MADD with alu_sub=1; 01 -> MADD with alu_sub=0; 00/11 -> MSHR.
//    MADD: a_sel=11, a_src=1; then MSHR.
//    MSHR: a_sel=01, q_sel=01 (arithmetic A:Q:Q[-1] shift right), cnt++.
//      cnt==N-1 -> DONE, else MTEST.
//  DIV loop (CTRL_DIV_EN only):
//    DSHL: a_sel=10, q_sel=10.
//    DSUB: a_sel=11, a_src=1, alu_sub=1.
//    DTST: a_sign=1 -> DRST; else q0_wr=1, q0_val=1, cnt++, then loop/exit.
//    DRST: a_sel=11, a_src=1, alu_sub=0, q0_wr=1, q0_val=0, cnt++.
//    Exit rule: cnt==N-1 at increment -> DONE, else DSHL.
//  DONE (1 cycle): done=1, busy=1, selects hold; -> IDLE. Result: MUL {A[15:0],Q}; DIV Q=quotient, A=remainder.
//  MUL latency, start-accept edge to done: 2+2N+(number of MADD visits); range 2+2N..2+3N.
//  start while busy is ignored (no queueing); a new start is accepted at the earliest in the cycle after DONE.
//  cnt wraps only through the LOAD clear; it never exceeds N-1.
//  rst mid-operation: immediate IDLE, outputs 0; datapath contents are undefined and not relied on.
// CONFIGURATION
//  CTRL_DIV_EN defined: DCHK/DSHL/DSUB/DTST/DRST states exist; op=1 runs the restoring divide.
//  CTRL_DIV_EN undefined: DIV states are absent; op=1 goes LOAD -> DONE with err=1.
//    Only the LOAD-cycle datapath writes occur; MUL is unaffected.
// TESTING  (controller paired with a behavioural A/Q/M datapath model)
//  MUL 0x0003 x 0x0005 -> {A[15:0],Q}=0x0000000F, err=0, single done pulse.
//  MUL 0xFFFE x 0x0007 -> 0xFFFFFFF2.
//    Q=0x0000 -> done 34 cycles after accept.
//    Q=0xFFFF -> 35 cycles.
//    Q=0x5555 -> 50 cycles.
//  start pulsed again at cycle 10 of a MUL -> ignored, result and timing unchanged.
//    rst at cycle 12 -> busy=0 and all selects 00 immediately.
//  DIV 100/7 with CTRL_DIV_EN -> Q=14, A=2, err=0.
//    DIV with M=0 -> done with err=1, no DSHL entered.
//  DIV request without CTRL_DIV_EN -> done+err 2 cycles after accept; a following MUL 3x5 is still correct.

Source files
------------

// File: rtl/booth_seq_ctrl.sv
// Booth multiply / restoring divide sequencer for the ALU16 shift-add datapath.
// Define CTRL_DIV_EN to build the divide states; otherwise op=1 ends in err.
module booth_seq_ctrl #(
    parameter int N     = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic             q0,
    input  logic             qm1,
    input  logic             a_sign,
    input  logic             m_zero,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       a_sel,
    output logic             a_src,
    output logic [1:0]       q_sel,
    output logic             m_ld,
    output logic             alu_sub,
    output logic             q0_wr,
    output logic             q0_val,
    output logic             qm1_clr,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

`ifdef CTRL_DIV_EN
    typedef enum logic [3:0] {
        IDLE, LOAD, MTEST, MADD, MSHR, DONE,
        DCHK, DSHL, DSUB, DTST, DRST
    } state_t;
`else
    typedef enum logic [3:0] {
        IDLE, LOAD, MTEST, MADD, MSHR, DONE
    } state_t;
`endif

    state_t           state, state_n;
    logic             op_q, op_n;
    logic             err_q, err_n;
    logic             sub_q, sub_n;
    logic [CNT_W-1:0] cnt_n;
    logic             last;

    assign last = (cnt == CNT_W'(N - 1));

`ifndef CTRL_DIV_EN
    logic div_unused;
    assign div_unused = ^{a_sign, m_zero};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op_q  <= 1'b0;
            err_q <= 1'b0;
            sub_q <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            op_q  <= op_n;
            err_q <= err_n;
            sub_q <= sub_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        op_n    = op_q;
        err_n   = err_q;
        sub_n   = sub_q;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    op_n    = op;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                cnt_n = '0;
                err_n = 1'b0;
                if (!op_q) begin
                    state_n = MTEST;
                end else begin
`ifdef CTRL_DIV_EN
                    state_n = DCHK;
`else
                    err_n   = 1'b1;
                    state_n = DONE;
`endif
                end
            end
            MTEST: begin
                unique case (1'b1)
                    (q0 && !qm1): begin
                        sub_n   = 1'b1;
                        state_n = MADD;
                    end
                    (!q0 && qm1): begin
                        sub_n   = 1'b0;
                        state_n = MADD;
                    end
                    default: state_n = MSHR;
                endcase
            end
            MADD: state_n = MSHR;
            // the final iteration leaves cnt at N-1
            MSHR: begin
                if (last) begin
                    state_n = DONE;
                end else begin
                    cnt_n   = cnt + 1'b1;
                    state_n = MTEST;
                end
            end
            DONE: state_n = IDLE;
`ifdef CTRL_DIV_EN
            DCHK: begin
                if (m_zero) begin
                    err_n   = 1'b1;
                    state_n = DONE;
                end else begin
                    state_n = DSHL;
                end
            end
            DSHL: state_n = DSUB;
            DSUB: state_n = DTST;
            DTST, DRST: begin
                if (state == DTST && a_sign) begin
                    state_n = DRST;
                end else if (last) begin
                    state_n = DONE;
                end else begin
                    cnt_n   = cnt + 1'b1;
                    state_n = DSHL;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        done    = 1'b0;
        err     = 1'b0;
        a_sel   = SEL_HOLD;
        a_src   = 1'b0;
        q_sel   = SEL_HOLD;
        m_ld    = 1'b0;
        alu_sub = 1'b0;
        q0_wr   = 1'b0;
        q0_val  = 1'b0;
        qm1_clr = 1'b0;
        unique case (state)
            LOAD: begin
                m_ld    = 1'b1;
                q_sel   = SEL_LOAD;
                a_sel   = SEL_LOAD;
                qm1_clr = 1'b1;
            end
            MADD: begin
                a_sel   = SEL_LOAD;
                a_src   = 1'b1;
                alu_sub = sub_q;
            end
            MSHR: begin
                a_sel = SEL_SHR;
                q_sel = SEL_SHR;
            end
            DONE: begin
                done = 1'b1;
                err  = err_q;
            end
`ifdef CTRL_DIV_EN
            DSHL: begin
                a_sel = SEL_SHL;
                q_sel = SEL_SHL;
            end
            DSUB: begin
                a_sel   = SEL_LOAD;
                a_src   = 1'b1;
                alu_sub = 1'b1;
            end
            DTST: begin
                if (!a_sign) begin
                    q0_wr  = 1'b1;
                    q0_val = 1'b1;
                end
            end
            DRST: begin
                a_sel  = SEL_LOAD;
                a_src  = 1'b1;
                q0_wr  = 1'b1;
                q0_val = 1'b0;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Bench for booth_seq_ctrl with a behavioural A/Q/M datapath.
// Expected products, quotients and latencies come from plain arithmetic.
module tb_booth_seq_ctrl;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic        q0, qm1, a_sign, m_zero;
    logic        busy, done, err;
    logic [1:0]  a_sel, q_sel;
    logic        a_src, m_ld, alu_sub, q0_wr, q0_val, qm1_clr;
    logic [4:0]  cnt;

    logic [16:0] a_q = '0;
    logic [15:0] q_q = '0;
    logic [15:0] m_q = '0;
    logic        qm1_q = 1'b0;
    logic [15:0] q_bus = '0;
    logic [15:0] m_bus = '0;
    logic        div_md = 1'b0;
    logic [16:0] m_ext, a_sum;

    int n_vec = 0;
    int n_bad = 0;
    int ndone = 0;
    logic saw_shl = 1'b0;
    logic cnt_ovf = 1'b0;

    always #5 clk = ~clk;

    booth_seq_ctrl #(.N(N), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .q0(q0), .qm1(qm1), .a_sign(a_sign), .m_zero(m_zero),
        .busy(busy), .done(done), .err(err),
        .a_sel(a_sel), .a_src(a_src), .q_sel(q_sel), .m_ld(m_ld),
        .alu_sub(alu_sub), .q0_wr(q0_wr), .q0_val(q0_val),
        .qm1_clr(qm1_clr), .cnt(cnt)
    );

    assign q0     = q_q[0];
    assign qm1    = qm1_q;
    assign a_sign = a_q[16];
    assign m_zero = (m_q == 16'd0);
    assign m_ext  = div_md ? {1'b0, m_q} : {m_q[15], m_q};
    assign a_sum  = alu_sub ? a_q - m_ext : a_q + m_ext;

    always @(posedge clk) begin
        case (a_sel)
            2'b01: a_q <= {a_q[16], a_q[16:1]};
            2'b10: a_q <= {a_q[15:0], q_q[15]};
            2'b11: a_q <= a_src ? a_sum : 17'd0;
            default: ;
        endcase
        case (q_sel)
            2'b01: q_q <= {a_q[0], q_q[15:1]};
            2'b10: q_q <= {q_q[14:0], 1'b0};
            2'b11: q_q <= q_bus;
            default: ;
        endcase
        if (q0_wr) q_q[0] <= q0_val;
        if (q_sel == 2'b01) qm1_q <= q_q[0];
        if (qm1_clr) qm1_q <= 1'b0;
        if (m_ld) m_q <= m_bus;
    end

    always @(negedge clk) begin
        if (done) ndone <= ndone + 1;
        if (a_sel == 2'b10) saw_shl <= 1'b1;
        if (cnt > 5'(N - 1)) cnt_ovf <= 1'b1;
    end

    typedef struct {
        string       nm;
        logic        op;
        logic [15:0] q;
        logic [15:0] m;
        logic [31:0] res;
        logic        err;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic run_op(input logic op_i, input logic [15:0] q_i,
                          input logic [15:0] m_i, input int poke,
                          output logic [31:0] res, output logic e,
                          output int lat, output logic [4:0] c);
        @(negedge clk);
        op = op_i; div_md = op_i; q_bus = q_i; m_bus = m_i;
        start = 1'b1;
        ndone = 0; saw_shl = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0; res = '0; e = 1'b0; c = '0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k + 1;
                res = {a_q[15:0], q_q};
                e   = err;
                c   = cnt;
                break;
            end
            start = (k == poke);
        end
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_vec(input vec_t v, input int poke);
        logic [31:0] res;
        logic e;
        int lat;
        logic [4:0] c;
        run_op(v.op, v.q, v.m, poke, res, e, lat, c);
        chk({v.nm, " err"}, 64'(e), 64'(v.err));
        chk({v.nm, " lat"}, 64'(lat), 64'(v.lat));
        chk({v.nm, " pulses"}, 64'(ndone), 64'd1);
        chk({v.nm, " idle"}, 64'({busy, done}), 64'd0);
        if (!v.err) begin
            chk({v.nm, " res"}, 64'(res), 64'(v.res));
            chk({v.nm, " cnt"}, 64'(c), 64'(N - 1));
        end else begin
            chk({v.nm, " noshl"}, 64'(saw_shl), 64'd0);
        end
    endtask

    function automatic int booth_adds(input logic [15:0] q);
        int n = 0;
        logic prev = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (q[i] != prev) n++;
            prev = q[i];
        end
        return n;
    endfunction

    function automatic vec_t mul_vec(input string nm, input logic [15:0] q,
                                     input logic [15:0] m);
        vec_t v;
        int p;
        p = int'($signed(q)) * int'($signed(m));
        v = '{nm, 1'b0, q, m, 32'(p), 1'b0, 2 + 2 * N + booth_adds(q)};
        return v;
    endfunction

`ifdef CTRL_DIV_EN
    function automatic vec_t div_vec(input string nm, input logic [15:0] q,
                                     input logic [15:0] m);
        vec_t v;
        logic [15:0] quo, rem;
        int zeros;
        quo = q / m;
        rem = q % m;
        zeros = N - $countones(quo);
        v = '{nm, 1'b1, q, m, {rem, quo}, 1'b0, 3 + 3 * N + zeros};
        return v;
    endfunction
`endif

    initial begin
        vec_t v;
        logic [31:0] res;
        logic e;
        int lat;
        logic [4:0] c;

        tbl.push_back('{"mul3x5", 1'b0, 16'h0003, 16'h0005,
                        32'h0000000F, 1'b0, 36});
        tbl.push_back('{"mulneg", 1'b0, 16'hFFFE, 16'h0007,
                        32'hFFFFFFF2, 1'b0, 35});
        tbl.push_back('{"q0000", 1'b0, 16'h0000, 16'h1234,
                        32'h00000000, 1'b0, 34});
        tbl.push_back('{"qffff", 1'b0, 16'hFFFF, 16'h0003,
                        32'hFFFFFFFD, 1'b0, 35});
        tbl.push_back('{"q5555", 1'b0, 16'h5555, 16'h0002,
                        32'h0000AAAA, 1'b0, 50});
        tbl.push_back('{"minmin", 1'b0, 16'h8000, 16'h8000,
                        32'h40000000, 1'b0, 35});
        tbl.push_back('{"maxmin", 1'b0, 16'h7FFF, 16'h8000,
                        32'hC0008000, 1'b0, 36});
`ifdef CTRL_DIV_EN
        tbl.push_back('{"div100_7", 1'b1, 16'd100, 16'd7,
                        {16'd2, 16'd14}, 1'b0, 64});
        tbl.push_back('{"divzero", 1'b1, 16'd100, 16'd0,
                        32'h0, 1'b1, 3});
`else
        tbl.push_back('{"divoff", 1'b1, 16'd100, 16'd7,
                        32'h0, 1'b1, 2});
`endif
        tbl.push_back('{"mulafter", 1'b0, 16'h0003, 16'h0005,
                        32'h0000000F, 1'b0, 36});

        repeat (3) @(posedge clk);
        #1;
        chk("reset outs", 64'({busy, done, err, a_sel, a_src, q_sel, m_ld,
            alu_sub, q0_wr, q0_val, qm1_clr, cnt}), 64'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle outs", 64'({busy, done, err, a_sel, q_sel, m_ld, cnt}),
            64'd0);

        foreach (tbl[i]) do_vec(tbl[i], 0);

        v = tbl[4];
        v.nm = "poke10";
        do_vec(v, 10);

        @(negedge clk);
        op = 1'b0; div_md = 1'b0; q_bus = 16'h5555; m_bus = 16'h0002;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("pre-rst busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst sels", 64'({a_sel, q_sel, m_ld, done, cnt}), 64'd0);
        @(negedge clk) rst = 1'b0;
        do_vec(tbl[0], 0);

        for (int r = 0; r < 24; r++) begin
            v = mul_vec("rndmul", 16'($urandom), 16'($urandom));
            do_vec(v, 0);
        end
`ifdef CTRL_DIV_EN
        for (int r = 0; r < 12; r++) begin
            v = div_vec("rnddiv", 16'($urandom),
                        16'($urandom_range(1, 65535)));
            do_vec(v, 0);
        end
`endif

        run_op(1'b0, 16'h0000, 16'h0000, 0, res, e, lat, c);
        chk("zero res", 64'(res), 64'd0);
        chk("cnt bound", 64'(cnt_ovf), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
